sccb_write: RTL and testbench

//  SCCB 3-phase write master for OV-series camera configuration.

---
 rtl/sccb_if.sv | 26 ++
 rtl/sccb_write.sv | 128 ++++++++++++
 tb/tb_sccb_write.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sccb_if.sv
// SCCB write-master bundle: request handshake plus the SIO_C/SIO_D pad signals.
// "master" is the view of the SCCB write engine; "slave" is the requester/pad side.
interface sccb_if;
  logic       req;
  logic [7:0] wr_id;
  logic [7:0] wr_sub;
  logic [7:0] wr_data;
  logic       rdy;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       sio_c;
  logic       sio_d;
  logic       sio_d_oe;
  logic       sio_din;

  modport master (
    input  req, wr_id, wr_sub, wr_data, sio_din,
    output rdy, busy, done, ack_err, sio_c, sio_d, sio_d_oe
  );

  modport slave (
    output req, wr_id, wr_sub, wr_data, sio_din,
    input  rdy, busy, done, ack_err, sio_c, sio_d, sio_d_oe
  );
endinterface

// File: rtl/sccb_write.sv
// SCCB 3-phase write master: START, ID+X, SUB+X, DATA+X, STOP, then an idle gap.
// Each SIO_C bit slot is CLK_DIV clocks; all bus and status outputs are registered.
module sccb_write #(
  parameter int unsigned CLK_DIV    = 50,
  parameter int unsigned GAP_CYCLES = 100
) (
  input  logic   clk,
  input  logic   rst_n,
  sccb_if.master bus
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  localparam logic [CW-1:0] CycQ    = CW'(CLK_DIV / 4);
  localparam logic [CW-1:0] CycH    = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0] Cyc3Q   = CW'(3 * CLK_DIV / 4);
  localparam logic [CW-1:0] CycLast = CW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GapLast = GW'(GAP_CYCLES - 1);
  localparam logic [4:0]    SlotStop = 5'd28;

  typedef enum logic [1:0] {StIdle, StXfer, StGap} state_e;

  state_e        state_q;
  logic [CW-1:0] cyc_q;
  logic [4:0]    slot_q;
  logic [GW-1:0] gap_q;
  logic [26:0]   shift_q;
  logic          err_q;
  logic          sio_c_q, sio_d_q, oe_q;
  logic          rdy_q, busy_q, done_q, ack_err_q;
  logic          is_x_slot;

  // Acknowledge (X) slots follow each byte; the pad is released there.
  assign is_x_slot = (slot_q == 5'd9) || (slot_q == 5'd18) || (slot_q == 5'd27);

  // Frame sequencer: slot/cycle counters, wire waveform and status, all in one register block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cyc_q     <= '0;
      slot_q    <= '0;
      gap_q     <= '0;
      shift_q   <= '0;
      err_q     <= 1'b0;
      sio_c_q   <= 1'b1;
      sio_d_q   <= 1'b1;
      oe_q      <= 1'b1;
      rdy_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.req) begin
            state_q   <= StXfer;
            cyc_q     <= '0;
            slot_q    <= '0;
            // X positions hold 1 so the released line idles high; ID bit0 is the write flag.
            shift_q   <= {bus.wr_id[7:1], bus.wr_id[0] & 1'b0, 1'b1,
                          bus.wr_sub, 1'b1, bus.wr_data, 1'b1};
            err_q     <= 1'b0;
            ack_err_q <= 1'b0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        StXfer: begin
          if (slot_q == 5'd0) begin
            if (cyc_q == CycQ) sio_d_q <= 1'b0;
          end else if (slot_q == SlotStop) begin
            if (cyc_q == '0) sio_c_q <= 1'b0;
            if (cyc_q == CycQ) begin
              sio_d_q <= 1'b0;
              oe_q    <= 1'b1;
            end
            if (cyc_q == CycH) sio_c_q <= 1'b1;
            if (cyc_q == Cyc3Q) sio_d_q <= 1'b1;
          end else begin
            if (cyc_q == '0) sio_c_q <= 1'b0;
            if (cyc_q == CycQ) begin
              sio_d_q <= shift_q[26];
              shift_q <= {shift_q[25:0], 1'b0};
              oe_q    <= ~is_x_slot;
            end
            if (cyc_q == CycH) sio_c_q <= 1'b1;
            if (cyc_q == Cyc3Q && is_x_slot && bus.sio_din) err_q <= 1'b1;
          end

          if (cyc_q == CycLast) begin
            cyc_q <= '0;
            if (slot_q == SlotStop) begin
              state_q   <= StGap;
              gap_q     <= '0;
              done_q    <= 1'b1;
              ack_err_q <= err_q;
            end else begin
              slot_q <= slot_q + 5'd1;
            end
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        StGap: begin
          if (gap_q == GapLast) begin
            state_q <= StIdle;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.sio_c    = sio_c_q;
  assign bus.sio_d    = sio_d_q;
  assign bus.sio_d_oe = oe_q;
  assign bus.rdy      = rdy_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.ack_err  = ack_err_q;

endmodule

// File: tb/tb_sccb_write.sv
// Bench for sccb_write: wire-level frame decoder, protocol monitor and expected-frame queue.
module tb_sccb_write;
  localparam int unsigned ClkDiv    = 8;
  localparam int unsigned GapCycles = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sccb_if bus();

  sccb_write #(
    .CLK_DIV   (ClkDiv),
    .GAP_CYCLES(GapCycles)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [26:0] bits;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Slave answers high only in the second X slot of a frame when asked to.
  logic        din_force = 1'b0;
  int unsigned oe_falls = 0;
  assign bus.sio_din = din_force & ~bus.sio_d_oe & (oe_falls == 2);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [26:0] exp_bits(input logic [7:0] id, input logic [7:0] sub,
                                           input logic [7:0] data);
    return {id[7:1], 1'b0, 1'b1, sub, 1'b1, data, 1'b1};
  endfunction

  // Monitor state
  int          cyc = 0;
  logic        prev_c = 1'b1, prev_d = 1'b1, prev_oe = 1'b1, prev_rdy = 1'b1, prev_done = 1'b0;
  logic        in_frame = 1'b0;
  int          bit_cnt = 0;
  logic [26:0] frame_bits = '0;
  logic        stop_seen = 1'b0;
  int          oe_low = 0;
  int          viol = 0;
  int          acc_cyc = 0, last_done_cyc = 0;
  int          acc_cnt = 0, done_cnt = 0;
  logic        b2b_mode = 1'b0, gap_armed = 1'b0;

  // Decode the wire, police SIO_D/OE rules and score each frame at done.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      in_frame  = 1'b0;
      bit_cnt   = 0;
      stop_seen = 1'b0;
      oe_falls  = 0;
    end else begin
      if (prev_rdy && !bus.rdy) begin
        acc_cyc = cyc;
        acc_cnt++;
        if (b2b_mode && gap_armed) check("b2b_gap", cyc - last_done_cyc, GapCycles + 1);
        gap_armed = 1'b0;
        stop_seen = 1'b0;
      end
      if (prev_c && bus.sio_c && (prev_d != bus.sio_d)) begin
        if (!bus.sio_d && !in_frame) begin
          in_frame = 1'b1;
          bit_cnt  = 0;
          oe_low   = 0;
          oe_falls = 0;
        end else if (bus.sio_d && in_frame && bit_cnt == 27) begin
          in_frame  = 1'b0;
          stop_seen = 1'b1;
        end else begin
          viol++;
        end
      end
      if (!prev_c && bus.sio_c && in_frame && bit_cnt < 27) begin
        frame_bits = {frame_bits[25:0], bus.sio_d};
        // OE must be low on exactly the three X bits.
        if (bus.sio_d_oe == (bit_cnt == 8 || bit_cnt == 17 || bit_cnt == 26)) viol++;
        bit_cnt++;
      end
      if (!bus.sio_d_oe) begin
        if (!in_frame) viol++;
        oe_low++;
      end
      if (prev_oe && !bus.sio_d_oe) oe_falls++;
      if (prev_done && bus.done) viol++;
      if (bus.done) begin
        done_cnt++;
        last_done_cyc = cyc;
        gap_armed     = 1'b1;
        check("sb_has_entry", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("frame_bits", frame_bits, e.bits);
          check("ack_err", bus.ack_err, e.err);
          check("done_latency", cyc - acc_cyc, 29 * ClkDiv);
          check("stop_seen", stop_seen, 1);
          check("oe_low_cycles", oe_low, 3 * ClkDiv);
        end
      end
    end
    prev_c    = bus.sio_c;
    prev_d    = bus.sio_d;
    prev_oe   = bus.sio_d_oe;
    prev_rdy  = bus.rdy;
    prev_done = bus.done;
  end

  task automatic send(input logic [7:0] id, input logic [7:0] sub, input logic [7:0] data,
                      input logic err);
    int t = 0;
    @(negedge clk);
    while (!bus.rdy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("rdy_wait", bus.rdy, 1);
    bus.req     = 1'b1;
    bus.wr_id   = id;
    bus.wr_sub  = sub;
    bus.wr_data = data;
    sb_q.push_back('{bits: exp_bits(id, sub, data), err: err});
    @(negedge clk);
    bus.req = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_cnt < target && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("done_timeout", done_cnt >= target, 1);
  endtask

  initial begin
    int base;
    int t;
    bus.req     = 1'b0;
    bus.wr_id   = '0;
    bus.wr_sub  = '0;
    bus.wr_data = '0;
    repeat (3) @(negedge clk);
    check("rst_sio_c", bus.sio_c, 1);
    check("rst_sio_d", bus.sio_d, 1);
    check("rst_oe", bus.sio_d_oe, 1);
    check("rst_rdy", bus.rdy, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_ack_err", bus.ack_err, 0);
    rst_n = 1'b1;

    // Basic frame, clean acknowledge.
    send(8'h43, 8'h12, 8'h80, 1'b0);
    check("busy_in_xfer", bus.busy, 1);
    check("rdy_in_xfer", bus.rdy, 0);
    wait_done(1);
    repeat (GapCycles + 2) @(negedge clk);
    check("rdy_after_gap", bus.rdy, 1);
    check("idle_after_gap", bus.busy, 0);

    // NACK in the SUB acknowledge slot, held, then cleared by a clean frame.
    din_force = 1'b1;
    send(8'h43, 8'h12, 8'h80, 1'b1);
    wait_done(2);
    din_force = 1'b0;
    repeat (2) @(negedge clk);
    check("ack_err_hold", bus.ack_err, 1);
    send(8'h43, 8'h12, 8'h80, 1'b0);
    wait_done(3);

    // req held high: three back-to-back frames.
    repeat (GapCycles + 2) @(negedge clk);
    b2b_mode  = 1'b1;
    gap_armed = 1'b0;
    for (int i = 0; i < 3; i++) sb_q.push_back('{bits: exp_bits(8'h5A, 8'hA5, 8'h3C), err: 1'b0});
    base        = acc_cnt;
    bus.wr_id   = 8'h5A;
    bus.wr_sub  = 8'hA5;
    bus.wr_data = 8'h3C;
    bus.req     = 1'b1;
    t = 0;
    while (acc_cnt < base + 3 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    bus.req = 1'b0;
    wait_done(6);
    b2b_mode = 1'b0;
    repeat (GapCycles + 4) @(negedge clk);
    check("b2b_accepts", acc_cnt - base, 3);

    // req pulses during XFER and GAP are ignored.
    send(8'h21, 8'h34, 8'h56, 1'b0);
    repeat (60) @(negedge clk);
    bus.req   = 1'b1;
    bus.wr_id = 8'hFF;
    @(negedge clk);
    bus.req = 1'b0;
    wait_done(7);
    bus.req = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
    repeat (30) @(negedge clk);
    check("pulse_one_done", done_cnt, 7);
    check("pulse_sb_empty", sb_q.size(), 0);
    check("pulse_rdy", bus.rdy, 1);

    // Reset asserted inside slot 15.
    send(8'h43, 8'h12, 8'h80, 1'b0);
    repeat (15 * ClkDiv + 2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_sio_c", bus.sio_c, 1);
    check("midrst_sio_d", bus.sio_d, 1);
    check("midrst_oe", bus.sio_d_oe, 1);
    check("midrst_rdy", bus.rdy, 1);
    check("midrst_busy", bus.busy, 0);
    sb_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send(8'h78, 8'h9A, 8'hBC, 1'b0);
    wait_done(8);
    repeat (GapCycles + 2) @(negedge clk);
    check("final_done_count", done_cnt, 8);

    check("protocol_viol", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
